// File: rtl/noc_pkg.sv
// Flit framing constants, header field positions and the framing FSM encoding,
// shared by the input buffers and the LBDR routing stage.
package noc_pkg;

  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  // Field positions are counted down from the flit MSB.
  localparam int FLIT_ID_W       = 3;
  localparam int FLIT_ID_TOP_OFS = 1;
  localparam int DST_W           = 4;
  localparam int DST_TOP_OFS     = 4;

  typedef enum logic {
    IDLE,
    IN_PKT
  } frame_state_t;

endpackage

// File: rtl/input_fifo_frame_monitor.sv
// Write-side packet framing checker: tracks HEADER..TAIL framing on accepted
// writes and raises a sticky error on any violation or unknown flit code.
module frame_monitor
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [2:0] flit_id_i,
  output logic       frame_err_o
);

  frame_state_t state_q;
  logic         frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_err_q <= 1'b0;
    end else if (wr_en_i) begin
      case (flit_id_i)
        HEADER: begin
          // A HEADER inside a packet restarts framing from that header.
          if (state_q == IN_PKT) frame_err_q <= 1'b1;
          state_q <= IN_PKT;
        end
        BODY: begin
          if (state_q == IDLE) frame_err_q <= 1'b1;
        end
        TAIL: begin
          if (state_q == IDLE) frame_err_q <= 1'b1;
          else                 state_q     <= IDLE;
        end
        default: frame_err_q <= 1'b1;
      endcase
    end
  end

  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/input_fifo.sv
// Router input-port buffer: first-word-fall-through FIFO under credit flow
// control, exposing head flit fields to LBDR plus sticky error flags.
module input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  empty_q, full_q;
  logic                  credit_q, overflow_q, underflow_q;
  logic                  rd_ok, wr_ok;

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign rd_ok = read_en && !empty_q;
  assign wr_ok = valid_in && (!full_q || rd_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (wr_ok && !rd_ok)      count_d = count_q + (AW+1)'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == FULL_CNT);
      credit_q    <= rd_ok;
      overflow_q  <= overflow_q  | (valid_in && full_q && !rd_ok);
      underflow_q <= underflow_q | (read_en && empty_q);
    end
  end

  frame_monitor u_frame_monitor (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_ok),
    .flit_id_i   (data_in[DATA_WIDTH-FLIT_ID_TOP_OFS -: FLIT_ID_W]),
    .frame_err_o (frame_err)
  );

  assign data_out   = mem_q[rd_ptr_q];
  assign flit_id    = data_out[DATA_WIDTH-FLIT_ID_TOP_OFS -: FLIT_ID_W];
  assign dst_addr   = data_out[DATA_WIDTH-DST_TOP_OFS -: DST_W];
  assign empty      = empty_q;
  assign full       = full_q;
  assign credit_out = credit_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: doc/input_fifo.md
# input_fifo

Per-port input buffer of the NoC router; sits directly upstream of the LBDR routing stage. Accepts flits from the neighbouring router (or local NI) under credit-based flow control, stores them in a first-word-fall-through FIFO, and presents the head flit's `flit_id` and `dst_addr` plus `empty` to LBDR. A small framing monitor flags malformed packets.

## Interface
Parameters:
- `DATA_WIDTH`, 32: flit width in bits.
- `DEPTH`, 4: FIFO slots; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `valid_in`  in  1  upstream presents a flit this cycle.
- `data_in`  in  DATA_WIDTH  incoming flit.
- `read_en`  in  1  downstream allocator consumes the head flit.
- `data_out`  out  DATA_WIDTH  head flit, combinational from storage.
- `flit_id`  out  3  `data_out[DATA_WIDTH-1 -: 3]`.
- `dst_addr`  out  4  `data_out[DATA_WIDTH-4 -: 4]`; meaningful only when `flit_id` is HEADER.
- `empty`  out  1  FIFO holds no flit.
- `full`  out  1  occupancy equals DEPTH.
- `credit_out`  out  1  one-cycle pulse returning one slot to upstream.
- `overflow`  out  1  sticky: write attempted while full without a same-cycle read.
- `underflow`  out  1  sticky: `read_en` while empty.
- `frame_err`  out  1  sticky: framing violation at the write side.

## Operation
- Storage: DEPTH×DATA_WIDTH array, read pointer, write pointer (log2(DEPTH) bits, natural wrap), and occupancy count (log2(DEPTH)+1 bits).
- Write is accepted when `valid_in` and either not full or `read_en` with not empty in the same cycle. The flit is stored at the write pointer, which then advances.
- Read is accepted when `read_en` and not empty. The read pointer advances and the count decrements.
- Simultaneous accepted read and write leave the count unchanged. This applies when full: the write goes into the slot just freed.
- Rejected write when full: the flit is dropped, storage is unchanged, and `overflow` sets.
- Rejected read when empty: no state change, `underflow` sets, and `credit_out` is not pulsed.
- Framing monitor FSM, advanced on each accepted write:
  - IDLE: HEADER goes to IN_PKT. BODY or TAIL sets `frame_err` and stays in IDLE.
  - IN_PKT: BODY stays. TAIL goes to IDLE. HEADER sets `frame_err` and stays in IN_PKT, treated as the start of a new packet.
  - Flit codes HEADER=3'b001, BODY=3'b010, TAIL=3'b100. Any other code sets `frame_err` with no state change.
- Framing errors never block storage; the flit is still written.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - `empty`=1; `full`, `credit_out`, `overflow`, `underflow`, `frame_err` all 0.
  - Pointers and count 0; FSM in IDLE.
  - `data_out`, `flit_id`, `dst_addr` are don't-care while empty.
- Reset mid-packet discards all stored flits and returns the FSM to IDLE.
- Write latency: a flit accepted at edge t is visible on `data_out` with `empty`=0 after edge t. LBDR samples it at edge t+1.
- Read: `read_en` at edge t advances the head after edge t.
- `credit_out`: registered, high for exactly one cycle after each accepted read. Back-to-back reads give a continuous high.
- Upstream starts with DEPTH credits. Credit round-trip is handled by the upstream counter, not here.
- `full` and `empty` derive from the count, registered with it, and are never both 1.
- Flags set on the cycle after the offending edge.

## Structure
- Shared package `noc_pkg` holds the flit-id constants (HEADER/BODY/TAIL), `flit_id`/`dst_addr` field offsets, and the FSM enum `frame_state_t` {IDLE, IN_PKT}. LBDR uses the same constants.
- One natural sub-module: `frame_monitor` (FSM plus `frame_err`), fed with accepted-write strobe and `flit_id`.
- The FIFO core stays in `input_fifo`.

## Test plan
- Reset, then write HEADER with dst 4'b1010, then 2 BODY, then TAIL, with no reads → `empty`=0 one cycle after the first write; `flit_id`=3'b001, `dst_addr`=4'b1010; count 4; `full`=1; `frame_err`=0.
- Full FIFO with `valid_in`=1 and `read_en`=1 the same cycle → head advances, new flit stored, `full` stays 1, `overflow`=0, `credit_out`=1 on the next cycle.
- Full FIFO with `valid_in`=1 and `read_en`=0 → flit dropped, `overflow`=1 next cycle and held; the next 4 reads return the original 4 flits in order.
- Empty FIFO with `read_en`=1 → `underflow`=1, no `credit_out`, pointers unchanged.
- Write BODY first after reset → `frame_err`=1 and flit still stored. Write HEADER then HEADER → `frame_err`=1.
- 10 write/read pairs for DEPTH=4 → pointers wrap; data order preserved; exactly 10 `credit_out` pulses.
